// File: rtl/ltc2308_pkg.sv
// Shared constants, state encoding and config decode for the LTC2308 responder.
package ltc2308_pkg;

    // Config word bit positions, ordered {S/D, O/S, S1, S0, UNI, SLP}
    localparam int CFG_SD  = 5;
    localparam int CFG_OS  = 4;
    localparam int CFG_S1  = 3;
    localparam int CFG_S0  = 2;
    localparam int CFG_UNI = 1;
    localparam int CFG_SLP = 0;

    localparam logic [5:0]  CFG_DEFAULT  = 6'b100010;
    localparam logic [11:0] BIPOLAR_FLIP = 12'h800;

    typedef enum logic [1:0] {
        IDLE,
        CONV,
        READY
    } state_e;

    function automatic logic [2:0] cfg_channel(input logic [5:0] cfg);
        return {cfg[CFG_S1], cfg[CFG_S0], cfg[CFG_OS]};
    endfunction

endpackage

// File: rtl/ltc2308_sync_edge.sv
// Multi-flop synchronizer for an asynchronous pin with registered rise/fall pulses.
module ltc2308_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   prev_q, prev_d;
    logic                   rise_q, rise_d;
    logic                   fall_q, fall_d;

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], din};
        prev_d = sync_q[SYNC_STAGES-1];
        rise_d = sync_q[SYNC_STAGES-1] & ~prev_q;
        fall_d = ~sync_q[SYNC_STAGES-1] & prev_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            prev_q <= 1'b0;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
            rise_q <= rise_d;
            fall_q <= fall_d;
        end
    end

    assign rise = rise_q;
    assign fall = fall_q;

endmodule

// File: rtl/ltc2308_responder.sv
// LTC2308 device-side emulator: accepts CONVST/SCK/SDI from an ADC controller
// and serves FPGA-supplied channel values on SDO.
module ltc2308_responder
    import ltc2308_pkg::*;
#(
    parameter int CONV_CYCLES = 80,
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        adc_convst,
    input  logic        adc_sck,
    input  logic        adc_sdi,
    output logic        adc_sdo,
    input  logic [95:0] ch_data,
    output logic [5:0]  active_cfg,
    output logic        busy,
    output logic        proto_err
);

    localparam int CNT_W = 10;

    state_e                 state_q, state_d;
    logic [CNT_W-1:0]       conv_cnt_q, conv_cnt_d;
    logic [5:0]             rx_sr_q, rx_sr_d;
    logic [2:0]             rx_cnt_q, rx_cnt_d;
    logic [11:0]            tx_sr_q, tx_sr_d;
    logic [3:0]             tx_cnt_q, tx_cnt_d;
    logic [5:0]             cfg_q, cfg_d;
    logic                   sdo_q, sdo_d;
    logic                   perr_q, perr_d;
    logic [SYNC_STAGES-1:0] sdi_sync_q, sdi_sync_d;

    logic       convst_rise, convst_fall_unused;
    logic       sck_rise, sck_fall;
    logic       sdi_s;
    logic [5:0] cfg_next;

    ltc2308_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_convst_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (adc_convst),
        .rise  (convst_rise),
        .fall  (convst_fall_unused)
    );

    ltc2308_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sck_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (adc_sck),
        .rise  (sck_rise),
        .fall  (sck_fall)
    );

    function automatic logic [11:0] conv_result(input logic [5:0] cfg, input logic [95:0] ch);
        logic [2:0]  sel;
        logic [11:0] v;
        sel = cfg_channel(cfg);
        v   = ch[12*int'(sel) +: 12];
        if (!cfg[CFG_SD])
            v = BIPOLAR_FLIP;
        else if (!cfg[CFG_UNI])
            v = v ^ BIPOLAR_FLIP;
        return v;
    endfunction

    assign sdi_s    = sdi_sync_q[SYNC_STAGES-1];
    // A completed 6-bit frame becomes the config for the conversion it precedes
    assign cfg_next = (rx_cnt_q == 3'd6) ? rx_sr_q : cfg_q;

    always_comb begin
        state_d    = state_q;
        conv_cnt_d = conv_cnt_q;
        rx_sr_d    = rx_sr_q;
        rx_cnt_d   = rx_cnt_q;
        tx_sr_d    = tx_sr_q;
        tx_cnt_d   = tx_cnt_q;
        cfg_d      = cfg_q;
        sdo_d      = sdo_q;
        perr_d     = 1'b0;
        sdi_sync_d = {sdi_sync_q[SYNC_STAGES-2:0], adc_sdi};

        case (state_q)
            CONV: begin
                if (convst_rise || sck_rise)
                    perr_d = 1'b1;
                if (conv_cnt_q == CNT_W'(CONV_CYCLES - 1)) begin
                    state_d = READY;
                    sdo_d   = tx_sr_q[11];
                end else begin
                    conv_cnt_d = conv_cnt_q + CNT_W'(1);
                end
            end
            default: begin
                // IDLE and READY share behaviour; CONVST takes priority over SCK edges
                if (convst_rise) begin
                    if (rx_cnt_q != 3'd0 && rx_cnt_q != 3'd6) begin
                        perr_d   = 1'b1;
                        rx_cnt_d = 3'd0;
                    end else begin
                        state_d    = CONV;
                        cfg_d      = cfg_next;
                        tx_sr_d    = conv_result(cfg_next, ch_data);
                        conv_cnt_d = '0;
                        rx_cnt_d   = 3'd0;
                        tx_cnt_d   = 4'd0;
                        sdo_d      = 1'b0;
                    end
                end else begin
                    if (sck_rise && rx_cnt_q < 3'd6) begin
                        rx_sr_d  = {rx_sr_q[4:0], sdi_s};
                        rx_cnt_d = rx_cnt_q + 3'd1;
                    end
                    if (sck_fall) begin
                        if (tx_cnt_q < 4'd11) begin
                            tx_cnt_d = tx_cnt_q + 4'd1;
                            tx_sr_d  = {tx_sr_q[10:0], 1'b0};
                            sdo_d    = tx_sr_q[10];
                        end else if (tx_cnt_q == 4'd11) begin
                            tx_cnt_d = 4'd12;
                            sdo_d    = 1'b0;
                        end
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            conv_cnt_q <= '0;
            rx_sr_q    <= '0;
            rx_cnt_q   <= '0;
            tx_sr_q    <= '0;
            tx_cnt_q   <= '0;
            cfg_q      <= CFG_DEFAULT;
            sdo_q      <= 1'b0;
            perr_q     <= 1'b0;
            sdi_sync_q <= '0;
        end else begin
            state_q    <= state_d;
            conv_cnt_q <= conv_cnt_d;
            rx_sr_q    <= rx_sr_d;
            rx_cnt_q   <= rx_cnt_d;
            tx_sr_q    <= tx_sr_d;
            tx_cnt_q   <= tx_cnt_d;
            cfg_q      <= cfg_d;
            sdo_q      <= sdo_d;
            perr_q     <= perr_d;
            sdi_sync_q <= sdi_sync_d;
        end
    end

    assign adc_sdo    = sdo_q;
    assign active_cfg = cfg_q;
    assign busy       = (state_q == CONV);
    assign proto_err  = perr_q;

endmodule
